cordic_rotator: RTL and testbench

Iterative rotation-mode CORDIC engine: rotates a signed (x, y) vector by a binary-angle z using one micro-rotation per clock. It is the arithmetic datapath stage driven by the control sequencer. It accepts operands over a valid/ready handshake and returns the rotated vector plus residual angle over a second valid/ready handshake.

---
 rtl/cordic_rotator_if.sv | 27 ++
 rtl/cordic_rotator.sv | 149 ++++++++++++++
 tb/tb_cordic_rotator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_rotator_if.sv
// Operand and result handshake bundle for cordic_rotator.
// The slave modport is the engine side; the master modport is the sequencer side.
interface cordic_rotator_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [WIDTH-1:0] x_i;
  logic signed [WIDTH-1:0] y_i;
  logic signed [15:0]      z_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic signed [WIDTH+1:0] x_o;
  logic signed [WIDTH+1:0] y_o;
  logic signed [15:0]      z_o;
  logic                    busy_o;

  modport slave (
    input  in_valid_i, x_i, y_i, z_i, out_ready_i,
    output in_ready_o, out_valid_o, x_o, y_o, z_o, busy_o
  );

  modport master (
    output in_valid_i, x_i, y_i, z_i, out_ready_i,
    input  in_ready_o, out_valid_o, x_o, y_o, z_o, busy_o
  );
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock; CORDIC_GAIN_COMP_EN adds a 1/K scaling state.
// Result valid ITER edges after accept (+1 with gain stage); result held in DONE while out_ready_i is low, no input overlap.
module cordic_rotator #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input logic              clk_i,
  input logic              rst_ni,
  cordic_rotator_if.slave  bus
);

  localparam int VW = WIDTH + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, GAIN = 2'd2, DONE = 2'd3} state_e;
  localparam logic signed [17:0] GAIN_K = 18'sd39797;
  logic signed [VW+17:0] x_prod, y_prod;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd3} state_e;
`endif

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic signed [VW-1:0] x_q, x_d, y_q, y_d;
  logic signed [15:0]   z_q, z_d;
  logic signed [VW-1:0] x_ext, y_ext, x_sh, y_sh;
  logic [15:0]          atan_c;

  assign x_ext = {{2{bus.x_i[WIDTH-1]}}, bus.x_i};
  assign y_ext = {{2{bus.y_i[WIDTH-1]}}, bus.y_i};
  assign x_sh  = x_q >>> cnt_q;
  assign y_sh  = y_q >>> cnt_q;

`ifdef CORDIC_GAIN_COMP_EN
  assign x_prod = (VW+18)'(x_q) * (VW+18)'(GAIN_K);
  assign y_prod = (VW+18)'(y_q) * (VW+18)'(GAIN_K);
`endif

  // round(atan(2^-i) * 32768 / pi)
  always_comb begin
    case (cnt_q)
      4'd0:    atan_c = 16'd8192;
      4'd1:    atan_c = 16'd4836;
      4'd2:    atan_c = 16'd2555;
      4'd3:    atan_c = 16'd1297;
      4'd4:    atan_c = 16'd651;
      4'd5:    atan_c = 16'd326;
      4'd6:    atan_c = 16'd163;
      4'd7:    atan_c = 16'd81;
      4'd8:    atan_c = 16'd41;
      4'd9:    atan_c = 16'd20;
      4'd10:   atan_c = 16'd10;
      4'd11:   atan_c = 16'd5;
      4'd12:   atan_c = 16'd3;
      4'd13:   atan_c = 16'd1;
      4'd14:   atan_c = 16'd1;
      default: atan_c = 16'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          cnt_d   = 4'd0;
          state_d = ROT;
          // Quadrant fold by +/-90 deg keeps the angle inside the convergence range.
          if (bus.z_i >= 16'sd16384) begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = bus.z_i - 16'sd16384;
          end else if (bus.z_i < -16'sd16384) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = bus.z_i + 16'sd16384;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = bus.z_i;
          end
        end
      end
      ROT: begin
        cnt_d = cnt_q + 4'd1;
        if (!z_q[15]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - $signed(atan_c);
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + $signed(atan_c);
        end
        if (cnt_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = GAIN;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      GAIN: begin
        x_d     = VW'(x_prod >>> 16);
        y_d     = VW'(y_prod >>> 16);
        state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE) && rst_ni;
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.x_o         = x_q;
  assign bus.y_o         = y_q;
  assign bus.z_o         = z_q;
`ifdef CORDIC_GAIN_COMP_EN
  assign bus.busy_o      = (state_q == ROT) || (state_q == GAIN);
`else
  assign bus.busy_o      = (state_q == ROT);
`endif

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed and random-angle bench for cordic_rotator; integer CORDIC model plus floating-point rotation check.
module tb_cordic_rotator;
  localparam int WIDTH = 16;
  localparam int ITER  = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = ITER + 1;
  localparam int  MAG = 10000;
  localparam real GK  = 39797.0 / 65536.0;
`else
  localparam int  LAT = ITER;
  localparam int  MAG = 16468;
  localparam real GK  = 1.0;
`endif
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_rotator_if #(.WIDTH(WIDTH)) bus ();

  cordic_rotator #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int A_TAB [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
  real k_gain;

  typedef struct {
    int x; int y; int z;
    int xi; int yi; int zi;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint req, input longint tol);
    longint diff;
    total++;
    diff = act - req;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d +/- %0d", name, act, req, tol);
    end
  endtask

  // Rotation-mode CORDIC on plain integers.
  function automatic void model(input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo);
    int x, y, z, t;
    longint p;
    x = xi; y = yi; z = zi;
    if (z >= 16384) begin
      t = x; x = -y; y = t; z = z - 16384;
    end else if (z < -16384) begin
      t = x; x = y; y = -t; z = z + 16384;
    end
    for (int i = 0; i < ITER; i++) begin
      int xs, ys;
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - A_TAB[i];
      end else begin
        x = x + ys; y = y - xs; z = z + A_TAB[i];
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    p = longint'(x) * 39797; x = int'(p >>> 16);
    p = longint'(y) * 39797; y = int'(p >>> 16);
`else
    p = 0;
`endif
    xo = x + int'(p - p); yo = y; zo = z;
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    real th, ex, ey;
    if (rst_n && bus.out_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale_valid: got out_valid_o=1 want 0 (no operation pending)");
      end else begin
        e = exp_q[0];
        check("x_model", bus.x_o, e.x);
        check("y_model", bus.y_o, e.y);
        check("z_model", bus.z_o, e.z);
        if (bus.out_ready_i) begin
          th = real'(e.zi - int'(bus.z_o)) * PI / 32768.0;
          ex = k_gain * GK * (real'(e.xi) * $cos(th) - real'(e.yi) * $sin(th));
          ey = k_gain * GK * (real'(e.xi) * $sin(th) + real'(e.yi) * $cos(th));
          check_near("x_float", bus.x_o, longint'(ex), ITER);
          check_near("y_float", bus.y_o, longint'(ey), ITER);
          check_near("z_resid", bus.z_o, 0, A_TAB[ITER-1] + 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_op(input int xv, input int yv, input int zv, input int hold,
                       output int xo, output int yo, output int zo);
    int cyc;
    int ex, ey, ez;
    exp_t n;
    logic signed [WIDTH+1:0] hx, hy;
    logic signed [15:0] hz;
    cyc = 0;
    while (!bus.in_ready_o && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("ready_before_op", bus.in_ready_o, 1);
    bus.x_i = 16'(xv);
    bus.y_i = 16'(yv);
    bus.z_i = 16'(zv);
    bus.in_valid_i = 1'b1;
    model(xv, yv, zv, ex, ey, ez);
    n.x = ex; n.y = ey; n.z = ez; n.xi = xv; n.yi = yv; n.zi = zv;
    exp_q.push_back(n);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.x_i = 16'h5a5a;
    bus.y_i = 16'ha5a5;
    bus.z_i = 16'h1234;
    check("busy_in_rot", bus.busy_o, 1);
    check("ready_in_rot", bus.in_ready_o, 0);
    cyc = 0;
    while (!bus.out_valid_o && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, LAT);
    check("ready_in_done", bus.in_ready_o, 0);
    check("busy_in_done", bus.busy_o, 0);
    hx = bus.x_o; hy = bus.y_o; hz = bus.z_o;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid_o, 1);
      check("hold_ready", bus.in_ready_o, 0);
      check("hold_x", bus.x_o, hx);
      check("hold_y", bus.y_o, hy);
      check("hold_z", bus.z_o, hz);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("valid_drop", bus.out_valid_o, 0);
    check("ready_back", bus.in_ready_o, 1);
    check("x_kept", bus.x_o, hx);
    check("y_kept", bus.y_o, hy);
    xo = int'(hx); yo = int'(hy); zo = int'(hz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xo, yo, zo;
    real p;
    k_gain = 1.0;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k_gain = k_gain * $sqrt(1.0 + p);
      p = p * 0.25;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.x_i = '0; bus.y_i = '0; bus.z_i = '0;

    #12;
    check("rst_x", bus.x_o, 0);
    check("rst_y", bus.y_o, 0);
    check("rst_z", bus.z_o, 0);
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_ready", bus.in_ready_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.in_ready_o, 1);
    check("post_rst_valid", bus.out_valid_o, 0);

    do_op(10000, 0, 0, 5, xo, yo, zo);
    check_near("lit_x_z0", xo, MAG, 14);
    check_near("lit_y_z0", yo, 0, 14);

    do_op(10000, 0, 16384, 0, xo, yo, zo);
    check_near("lit_x_z90", xo, 0, 14);
    check_near("lit_y_z90", yo, MAG, 14);

    do_op(10000, 0, -32768, 2, xo, yo, zo);
    check_near("lit_x_z180", xo, -MAG, 14);
    check_near("lit_y_z180", yo, 0, 14);

    do_op(0, 10000, -16384, 0, xo, yo, zo);
    check_near("lit_x_zm90", xo, MAG, 14);
    check_near("lit_y_zm90", yo, 0, 14);

    // Abort an operation after the fifth rotation edge.
    bus.x_i = 16'(10000); bus.y_i = 16'(3000); bus.z_i = 16'(5000);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_x", bus.x_o, 0);
    check("abort_y", bus.y_o, 0);
    check("abort_z", bus.z_o, 0);
    check("abort_valid", bus.out_valid_o, 0);
    check("abort_busy", bus.busy_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(10000, 0, 0, 1, xo, yo, zo);
    check_near("after_abort_x", xo, MAG, 14);

    for (int k = 0; k < 40; k++) begin
      int xv, yv, zv;
      xv = int'($urandom_range(0, 65534)) - 32767;
      yv = int'($urandom_range(0, 65534)) - 32767;
      zv = int'($urandom_range(0, 65535)) - 32768;
      do_op(xv, yv, zv, k % 3, xo, yo, zo);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
